// File: rtl/mmio_data_memory.sv
// Word-addressed data RAM for the MEM stage with a memory-mapped peripheral
// page at 0x4xxx_xxxx: LED and digit registers, a free-running cycle counter
// and N_TIMERS timer channels with one-shot/auto-reload and W1C flags.
//
// Bus semantics: MemRead and MemWrite are single-cycle requests that are
// always accepted (no ready). A write commits at the clk edge it is sampled
// on; a read returns the pre-edge value in Read_data after that same edge,
// and Read_data holds while MemRead is low.
module mmio_data_memory #(
  parameter int RAM_SIZE_BIT = 9,
  parameter int N_TIMERS     = 2,
  parameter int LED_W        = 8,
  parameter int DIG_W        = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         Write_data,
  input  logic [3:0]          Byte_en,
  input  logic                MemRead,
  input  logic                MemWrite,
  output logic [31:0]         Read_data,
  output logic [LED_W-1:0]    leds,
  output logic [DIG_W-1:0]    digits,
  output logic [N_TIMERS-1:0] tick,
  output logic                irq
);

  localparam int RAM_DEPTH = 1 << RAM_SIZE_BIT;

  logic [31:0] ram [RAM_DEPTH];

  logic [31:0] cycle_q;
  logic [31:0] reload_q [N_TIMERS];
  logic [31:0] count_q  [N_TIMERS];
  logic [N_TIMERS-1:0] enable_q;
  logic [N_TIMERS-1:0] irq_en_q;
  logic [N_TIMERS-1:0] flag_q;
  logic [N_TIMERS-1:0] oneshot_q;

  logic                    peri;
  logic [11:0]             offset;
  logic [7:0]              page;
  logic [RAM_SIZE_BIT-1:0] ram_idx;
  logic [31:0]             wmask;
  logic [31:0]             peri_rdata;
  logic                    peri_wr;
  logic                    wr_led;
  logic                    wr_dig;
  logic [N_TIMERS-1:0]     wr_reload;
  logic [N_TIMERS-1:0]     wr_count;
  logic [N_TIMERS-1:0]     wr_ctrl;
  logic                    unused_addr;

  assign peri    = (Address[31:28] == 4'h4);
  assign offset  = Address[11:0];
  assign page    = offset[11:4];
  assign ram_idx = Address[RAM_SIZE_BIT+1:2];
  assign wmask   = {{8{Byte_en[3]}}, {8{Byte_en[2]}}, {8{Byte_en[1]}}, {8{Byte_en[0]}}};
  assign peri_wr = MemWrite && peri;
  assign wr_led  = peri_wr && (offset[11:2] == 10'h000);
  assign wr_dig  = peri_wr && (offset[11:2] == 10'h001);

  // Address bits that only alias: byte offset and the unused middle of the map.
  assign unused_addr = ^{Address[27:12], Address[1:0]};

  // Per-timer write strobes decoded from page index and register slot.
  always_comb begin
    wr_reload = '0;
    wr_count  = '0;
    wr_ctrl   = '0;
    for (int k = 0; k < N_TIMERS; k++) begin
      if (peri_wr && (page == 8'(k + 1))) begin
        wr_reload[k] = (offset[3:2] == 2'd0);
        wr_count[k]  = (offset[3:2] == 2'd1);
        wr_ctrl[k]   = (offset[3:2] == 2'd2);
      end
    end
  end

  // Peripheral read mux over pre-edge register values; holes read as zero.
  always_comb begin
    peri_rdata = '0;
    if (page == 8'd0) begin
      case (offset[3:2])
        2'd0:    peri_rdata[LED_W-1:0] = leds;
        2'd1:    peri_rdata[DIG_W-1:0] = digits;
        2'd2:    peri_rdata = cycle_q;
        default: peri_rdata = '0;
      endcase
    end
    for (int k = 0; k < N_TIMERS; k++) begin
      if (page == 8'(k + 1)) begin
        case (offset[3:2])
          2'd0:    peri_rdata = reload_q[k];
          2'd1:    peri_rdata = count_q[k];
          2'd2:    peri_rdata = {28'd0, oneshot_q[k], flag_q[k], irq_en_q[k], enable_q[k]};
          default: peri_rdata = '0;
        endcase
      end
    end
  end

  // RAM byte-lane stores; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (MemWrite && !peri) begin
      for (int i = 0; i < 4; i++) begin
        if (Byte_en[i]) ram[ram_idx][8*i +: 8] <= Write_data[8*i +: 8];
      end
    end
  end

  // Registered load path, board registers, cycle counter and timer channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      Read_data <= '0;
      leds      <= '0;
      digits    <= '0;
      tick      <= '0;
      irq       <= 1'b0;
      cycle_q   <= '0;
      enable_q  <= '0;
      irq_en_q  <= '0;
      flag_q    <= '0;
      oneshot_q <= '0;
      for (int k = 0; k < N_TIMERS; k++) begin
        reload_q[k] <= '0;
        count_q[k]  <= '0;
      end
    end else begin
      cycle_q <= cycle_q + 32'd1;
      irq     <= |(flag_q & irq_en_q);

      if (MemRead) Read_data <= peri ? peri_rdata : ram[ram_idx];

      if (wr_led) leds   <= (leds & ~wmask[LED_W-1:0]) | (Write_data[LED_W-1:0] & wmask[LED_W-1:0]);
      if (wr_dig) digits <= (digits & ~wmask[DIG_W-1:0]) | (Write_data[DIG_W-1:0] & wmask[DIG_W-1:0]);

      for (int k = 0; k < N_TIMERS; k++) begin
        tick[k] <= 1'b0;

        // W1C comes first so a same-cycle overflow set below overrides it.
        if (wr_ctrl[k] && Byte_en[0] && Write_data[2]) flag_q[k] <= 1'b0;

        if (enable_q[k]) begin
          if (count_q[k] == 32'hFFFF_FFFF) begin
            count_q[k] <= reload_q[k];
            tick[k]    <= 1'b1;
            if (irq_en_q[k])  flag_q[k]   <= 1'b1;
            if (oneshot_q[k]) enable_q[k] <= 1'b0;
          end else begin
            count_q[k] <= count_q[k] + 32'd1;
          end
        end

        // CPU writes come last so they win over the timer's own update.
        if (wr_reload[k]) reload_q[k] <= (reload_q[k] & ~wmask) | (Write_data & wmask);
        if (wr_count[k])  count_q[k]  <= (count_q[k] & ~wmask) | (Write_data & wmask);
        if (wr_ctrl[k] && Byte_en[0]) begin
          enable_q[k]  <= Write_data[0];
          irq_en_q[k]  <= Write_data[1];
          oneshot_q[k] <= Write_data[3];
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_data_memory.sv
// Self-checking bench for mmio_data_memory: bus driver tasks, a read
// scoreboard queue, and one task per feature with inline comparisons.
module tb_mmio_data_memory;

  localparam int N_TIMERS = 2;
  localparam int LED_W    = 8;
  localparam int DIG_W    = 12;

  localparam logic [31:0] A_LED  = 32'h4000_0000;
  localparam logic [31:0] A_DIG  = 32'h4000_0004;
  localparam logic [31:0] A_CYC  = 32'h4000_0008;
  localparam logic [31:0] A_RLD0 = 32'h4000_0010;
  localparam logic [31:0] A_CNT0 = 32'h4000_0014;
  localparam logic [31:0] A_CTL0 = 32'h4000_0018;
  localparam logic [31:0] A_RLD1 = 32'h4000_0020;
  localparam logic [31:0] A_CNT1 = 32'h4000_0024;
  localparam logic [31:0] A_CTL1 = 32'h4000_0028;

  logic                clk = 1'b0;
  logic                reset;
  logic [31:0]         Address;
  logic [31:0]         Write_data;
  logic [3:0]          Byte_en;
  logic                MemRead;
  logic                MemWrite;
  logic [31:0]         Read_data;
  logic [LED_W-1:0]    leds;
  logic [DIG_W-1:0]    digits;
  logic [N_TIMERS-1:0] tick;
  logic                irq;

  logic [31:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  mmio_data_memory #(
    .RAM_SIZE_BIT(9),
    .N_TIMERS(N_TIMERS),
    .LED_W(LED_W),
    .DIG_W(DIG_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .Write_data(Write_data),
    .Byte_en(Byte_en),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .Read_data(Read_data),
    .leds(leds),
    .digits(digits),
    .tick(tick),
    .irq(irq)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: called just after a negedge, each consumes one posedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    Address = a; Write_data = d; Byte_en = be; MemWrite = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    MemWrite = 1'b0; Byte_en = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    Address = a; MemRead = 1'b1; MemWrite = 1'b0;
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    Address = '0; Write_data = '0; Byte_en = '0; MemRead = 1'b0; MemWrite = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (Read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", Read_data); end
    n_cmp++; if (leds !== 8'h0)       begin n_fail++; $display("FAIL reset_leds: got %h expected 0", leds); end
    n_cmp++; if (digits !== 12'h0)    begin n_fail++; $display("FAIL reset_digits: got %h expected 0", digits); end
    n_cmp++; if (tick !== 2'b00)      begin n_fail++; $display("FAIL reset_tick: got %b expected 00", tick); end
    n_cmp++; if (irq !== 1'b0)        begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_ram_bytes();
    logic [31:0] e;
    bus_write(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    bus_read(32'h0000_0010, 32'hDEAD_BEEF);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL ram_full_word: got %h expected %h", Read_data, e); end

    bus_write(32'h0000_0010, 32'h0000_00AA, 4'b0001);
    bus_read(32'h0000_0010, 32'hDEAD_BEAA);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL ram_byte0: got %h expected %h", Read_data, e); end

    bus_write(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
    bus_read(32'h0000_0010, 32'hDEAD_BEAA);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL ram_be_zero: got %h expected %h", Read_data, e); end

    bus_write(32'h0000_0010, 32'h1122_3344, 4'b1100);
    bus_read(32'h0000_0810, 32'h1122_BEAA);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL ram_upper_alias: got %h expected %h", Read_data, e); end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (Read_data !== 32'h1122_BEAA) begin n_fail++; $display("FAIL rdata_hold: got %h expected 1122beaa", Read_data); end
  endtask

  task automatic test_read_before_write();
    logic [31:0] e;
    exp_q.push_back(32'h1122_BEAA);
    Address = 32'h0000_0010; Write_data = 32'hCAFE_F00D; Byte_en = 4'hF;
    MemRead = 1'b1; MemWrite = 1'b1;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; Byte_en = 4'h0;
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL rbw_old: got %h expected %h", Read_data, e); end
    bus_read(32'h0000_0010, 32'hCAFE_F00D);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL rbw_new: got %h expected %h", Read_data, e); end
  endtask

  task automatic test_random_ram();
    logic [31:0] model [8];
    logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      bus_write(32'(64 + i) << 2, model[i], 4'hF);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(32'(64 + i) << 2, model[i]);
      e = exp_q.pop_front(); n_cmp++;
      if (Read_data !== e) begin n_fail++; $display("FAIL ram_random[%0d]: got %h expected %h", i, Read_data, e); end
    end
  endtask

  task automatic test_led_digits();
    logic [31:0] e;
    bus_write(A_LED, 32'h0000_01FF, 4'hF);
    n_cmp++; if (leds !== 8'hFF) begin n_fail++; $display("FAIL leds_narrow: got %h expected ff", leds); end
    bus_read(A_LED, 32'h0000_00FF);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL leds_read: got %h expected %h", Read_data, e); end
    bus_write(A_DIG, 32'h0000_ABCD, 4'b0011);
    n_cmp++; if (digits !== 12'hBCD) begin n_fail++; $display("FAIL digits_write: got %h expected bcd", digits); end
    bus_write(A_DIG, 32'h0000_0000, 4'b0010);
    n_cmp++; if (digits !== 12'h0CD) begin n_fail++; $display("FAIL digits_lane1: got %h expected 0cd", digits); end
    bus_write(32'h4000_000C, 32'h5555_5555, 4'hF);
    bus_read(32'h4000_000C, 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL hole_0c: got %h expected %h", Read_data, e); end
    bus_write(32'h4000_0030, 32'h7777_7777, 4'hF);
    bus_read(32'h4000_0030, 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL hole_timer2: got %h expected %h", Read_data, e); end
    bus_read(32'h4000_001C, 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL hole_1c: got %h expected %h", Read_data, e); end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] c1;
    logic [31:0] c2;
    int gap;
    gap = $urandom_range(3, 20);
    bus_read(A_CYC, 32'h0); void'(exp_q.pop_front());
    c1 = Read_data;
    repeat (gap - 1) @(negedge clk);
    bus_read(A_CYC, 32'h0); void'(exp_q.pop_front());
    c2 = Read_data;
    n_cmp++;
    if (c2 - c1 !== 32'(gap)) begin n_fail++; $display("FAIL cycle_delta: got %0d expected %0d", c2 - c1, gap); end
    bus_read(A_CYC, 32'h0); void'(exp_q.pop_front());
    c1 = Read_data;
    bus_write(A_CYC, 32'hFFFF_0000, 4'hF);
    bus_read(A_CYC, 32'h0); void'(exp_q.pop_front());
    c2 = Read_data;
    n_cmp++;
    if (c2 - c1 !== 32'd2) begin n_fail++; $display("FAIL cycle_ro: got %0d expected 2", c2 - c1); end
  endtask

  task automatic test_timer_reload();
    logic [31:0] e;
    logic [1:0]  exp_tick;
    logic        exp_irq;
    int          pulses;
    bus_write(A_RLD0, 32'hFFFF_FFFC, 4'hF);
    bus_write(A_CNT0, 32'hFFFF_FFFC, 4'hF);
    bus_write(A_CTL0, 32'h3, 4'hF);
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp_tick = (i % 4 == 0) ? 2'b01 : 2'b00;
      exp_irq  = (i >= 5);
      if (tick[0]) pulses++;
      n_cmp++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL tick0_period c%0d: got %b expected %b", i, tick, exp_tick); end
      n_cmp++;
      if (irq !== exp_irq) begin n_fail++; $display("FAIL irq0_delay c%0d: got %b expected %b", i, irq, exp_irq); end
    end
    n_cmp++;
    if (pulses != 2) begin n_fail++; $display("FAIL tick0_count: got %0d expected 2", pulses); end
    // Clear away from an overflow edge.
    bus_write(A_CTL0, 32'h7, 4'hF);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq0_w1c: got %b expected 0", irq); end
    bus_read(A_CTL0, 32'h3);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL ctl0_cleared: got %h expected %h", Read_data, e); end
    // Next overflow lands three cycles later; W1C on exactly that edge.
    repeat (3) @(negedge clk);
    bus_write(A_CTL0, 32'h7, 4'hF);
    bus_read(A_CTL0, 32'h7);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL w1c_vs_set: got %h expected %h", Read_data, e); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq0_kept: got %b expected 1", irq); end
    bus_write(A_CTL0, 32'h4, 4'hF);
    bus_read(A_CNT0, 32'hFFFF_FFFE);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL count0_hold: got %h expected %h", Read_data, e); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq0_off: got %b expected 0", irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] e;
    logic [1:0]  exp_tick;
    int          pulses;
    bus_write(A_RLD1, 32'h0000_0100, 4'hF);
    bus_write(A_CNT1, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_CTL1, 32'hB, 4'hF);
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      exp_tick = (i == 2) ? 2'b10 : 2'b00;
      if (tick[1]) pulses++;
      n_cmp++;
      if (tick !== exp_tick) begin n_fail++; $display("FAIL tick1_oneshot c%0d: got %b expected %b", i, tick, exp_tick); end
    end
    n_cmp++;
    if (pulses != 1) begin n_fail++; $display("FAIL tick1_count: got %0d expected 1", pulses); end
    bus_read(A_CTL1, 32'hE);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL ctl1_after: got %h expected %h", Read_data, e); end
    bus_read(A_CNT1, 32'h100);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL count1_reload: got %h expected %h", Read_data, e); end
    repeat (3) @(negedge clk);
    bus_read(A_CNT1, 32'h100);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL count1_hold: got %h expected %h", Read_data, e); end
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq1_set: got %b expected 1", irq); end
    bus_write(A_CTL1, 32'h4, 4'hF);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq1_clear: got %b expected 0", irq); end
  endtask

  task automatic test_cpu_wins();
    logic [31:0] e;
    // COUNT write while the timer is running.
    bus_write(A_CNT0, 32'h0000_0010, 4'hF);
    bus_write(A_CTL0, 32'h1, 4'hF);
    @(negedge clk);
    bus_write(A_CNT0, 32'h0000_0500, 4'hF);
    bus_read(A_CNT0, 32'h0000_0500);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL count_write_wins: got %h expected %h", Read_data, e); end
    bus_write(A_CTL0, 32'h0, 4'hF);
    // Enable rewrite on the one-shot auto-clear edge.
    bus_write(A_CNT1, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_CTL1, 32'h9, 4'hF);
    @(negedge clk);
    bus_write(A_CTL1, 32'h9, 4'hF);
    bus_read(A_CTL1, 32'h9);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL enable_write_wins: got %h expected %h", Read_data, e); end
    bus_write(A_CTL1, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    bus_write(32'h0000_000C, 32'h0000_1234, 4'hF);
    bus_write(A_LED, 32'hFF, 4'hF);
    bus_write(A_DIG, 32'h321, 4'hF);
    bus_write(A_RLD0, 32'hFFFF_FFFD, 4'hF);
    bus_write(A_CNT0, 32'hFFFF_FFFD, 4'hF);
    bus_write(A_CTL0, 32'h3, 4'hF);
    repeat ($urandom_range(3, 7)) @(negedge clk);
    pulse_reset();
    n_cmp++; if (leds !== 8'h0)       begin n_fail++; $display("FAIL rst_mid_leds: got %h expected 0", leds); end
    n_cmp++; if (digits !== 12'h0)    begin n_fail++; $display("FAIL rst_mid_digits: got %h expected 0", digits); end
    n_cmp++; if (irq !== 1'b0)        begin n_fail++; $display("FAIL rst_mid_irq: got %b expected 0", irq); end
    n_cmp++; if (tick !== 2'b00)      begin n_fail++; $display("FAIL rst_mid_tick: got %b expected 00", tick); end
    n_cmp++; if (Read_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected 0", Read_data); end
    bus_read(A_CNT0, 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL rst_mid_count0: got %h expected %h", Read_data, e); end
    bus_read(A_CTL0, 32'h0);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL rst_mid_ctl0: got %h expected %h", Read_data, e); end
    bus_read(32'h0000_000C, 32'h0000_1234);
    e = exp_q.pop_front(); n_cmp++;
    if (Read_data !== e) begin n_fail++; $display("FAIL rst_mid_ram: got %h expected %h", Read_data, e); end
  endtask

  initial begin
    test_reset();
    test_ram_bytes();
    test_read_before_write();
    test_random_ram();
    test_led_digits();
    test_cycle_counter();
    test_timer_reload();
    test_oneshot();
    test_cpu_wins();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
